data_memory_responder: RTL

Responder end of the processor data-memory interface. It consumes MemoryWrite, ALUResult (address) and WriteData, and returns ReadData.
Backs a word-addressed RAM and a small MMIO region: cycle counter, LED register, debug-output FIFO and status register.
Read path is combinational so a single-cycle core sees ReadData in the same cycle. All state updates occur on the rising clk edge.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dbg_fifo.sv | 51 +++++
 rtl/data_memory_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared decode constants for the data-memory responder.
// MMIO offsets, STATUS bit positions and region enum.
package dmem_pkg;

  localparam logic [3:0] OFF_CYCLE  = 4'h0;
  localparam logic [3:0] OFF_LED    = 4'h4;
  localparam logic [3:0] OFF_DBG    = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_MIS   = 3;
  localparam int ST_CNT   = 4;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_t;

endpackage

// File: rtl/dbg_fifo.sv
// Debug-output FIFO, power-of-two depth, show-ahead head word.
// Ports: clk, reset (async low), push/wdata, pop, full, empty, count, rdata.
module dbg_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   wdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [31:0]   rdata
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  // a pop frees the slot the push needs
  assign do_push = push && (!full || pop);
  assign count   = cnt;
  assign rdata   = empty ? 32'b0 : mem[rp];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: word RAM plus CYCLE/LED/DBG_TX/STATUS MMIO.
// Ports: clk, reset, MemoryWrite, ALUResult, WriteData, ReadData,
//   dbg_valid/dbg_data/dbg_ready, led. Option: ALIGN_CHECK_EN.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemoryWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        dbg_valid,
  output logic [31:0] dbg_data,
  input  logic        dbg_ready,
  output logic [7:0]  led
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] idx;
  region_t       region;
  logic [1:0]    off;
  logic          mis;
  logic          mis_flag;
  logic          wen;
  logic          mmio_we;
  logic          sel_cyc;
  logic          sel_led;
  logic          sel_dbg;
  logic          sel_st;
  logic [31:0]   cycle;
  logic [7:0]    led_q;
  logic          ovf;
  logic          ovf_set;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [31:0]   status;

  assign idx = ALUResult[AW+1:2];
  assign off = ALUResult[3:2];

  always_comb begin
    region = REG_NONE;
    if (ALUResult < 32'(RAM_WORDS * 4))
      region = REG_RAM;
    else if (ALUResult[31:4] == MMIO_BASE[31:4])
      region = REG_MMIO;
  end

`ifdef ALIGN_CHECK_EN
  logic mis_q;
  assign mis      = |ALUResult[1:0];
  assign mis_flag = mis_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      mis_q <= 1'b0;
    else if (MemoryWrite && mis)
      mis_q <= 1'b1;
    else if (sel_st && mmio_we && WriteData[ST_MIS])
      mis_q <= 1'b0;
  end
`else
  assign mis      = 1'b0;
  assign mis_flag = 1'b0;
`endif

  assign wen     = MemoryWrite && !mis;
  assign mmio_we = wen && (region == REG_MMIO);
  assign sel_cyc = (off == OFF_CYCLE[3:2]);
  assign sel_led = (off == OFF_LED[3:2]);
  assign sel_dbg = (off == OFF_DBG[3:2]);
  assign sel_st  = (off == OFF_STATUS[3:2]);

  always_ff @(posedge clk) begin
    if (wen && (region == REG_RAM))
      ram[idx] <= WriteData;
  end

  assign push    = mmio_we && sel_dbg;
  assign pop     = dbg_valid && dbg_ready;
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle <= '0;
      led_q <= '0;
      ovf   <= 1'b0;
    end else begin
      if (mmio_we && sel_cyc) cycle <= WriteData;
      else                    cycle <= cycle + 32'd1;
      if (mmio_we && sel_led) led_q <= WriteData[7:0];
      if (ovf_set)
        ovf <= 1'b1;
      else if (mmio_we && sel_st && WriteData[ST_OVF])
        ovf <= 1'b0;
    end
  end

  dbg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (WriteData),
    .full  (full),
    .empty (empty),
    .count (count),
    .rdata (dbg_data)
  );

  assign dbg_valid = !empty;
  assign led       = led_q;

  always_comb begin
    status             = 32'b0;
    status[ST_FULL]    = full;
    status[ST_EMPTY]   = empty;
    status[ST_OVF]     = ovf;
    status[ST_MIS]     = mis_flag;
    status[ST_CNT +: 5] = 5'(count);
  end

  always_comb begin
    ReadData = 32'b0;
    if (!mis) begin
      unique case (1'b1)
        region == REG_RAM:
          ReadData = ram[idx];
        region == REG_MMIO && sel_cyc:
          ReadData = cycle;
        region == REG_MMIO && sel_led:
          ReadData = {24'b0, led_q};
        region == REG_MMIO && sel_st:
          ReadData = status;
        default:
          ReadData = 32'b0;
      endcase
    end
  end

endmodule
